// File: rtl/debug_controller.sv
`timescale 1ns/1ps
// debug_controller: UART-driven debug master that loads imem, steps/runs the pipeline and dumps its state
module debug_controller #(
  parameter int NB          = 32,
  parameter int IMEM_WORDS  = 64,
  parameter int MEM_WORDS   = 16,
  parameter int CYCLE_LIMIT = 4096
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_step,
  output logic          o_instruction_write_enable,
  output logic [NB-1:0] o_instruction_address,
  output logic [NB-1:0] o_instruction_data,
  output logic [4:0]    o_debug_mips_register_number,
  output logic [NB-1:0] o_debug_address,
  input  logic [NB-1:0] i_mips_pc,
  input  logic [NB-1:0] i_mips_register_data,
  input  logic [NB-1:0] i_mips_data_memory,
  input  logic          i_mips_wb_halt,
  output logic          o_halted
);
  localparam int CW = $clog2(CYCLE_LIMIT + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(CYCLE_LIMIT - 1);
  localparam logic [5:0] LAST = 6'(32 + MEM_WORDS);
  localparam logic [8:0] IMEM_LIM = 9'(IMEM_WORDS);
  typedef enum logic [3:0] {IDLE, LD_CNT, LD_BYTE, LD_WR, ACK, STEP, RUN, DP_SEL, DP_LATCH, DP_SEND, TRAILER} state_t;
  state_t state;
  logic [1:0] bidx;
  logic [7:0] widx, wcnt;
  logic [5:0] didx;
  logic [CW-1:0] run_cnt;
  logic timeout;
  logic [NB-9:0] asm_w, shreg;
  logic accept;
  assign accept = o_tx_valid & i_tx_ready;
  // a run stops stepping in the very cycle the halt shows up in write-back
  assign o_step = (state == STEP) | ((state == RUN) & ~i_mips_wb_halt);
  // command decode, load assembly, step/run control and the dump serializer
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      bidx <= '0;
      widx <= '0;
      wcnt <= '0;
      didx <= '0;
      run_cnt <= '0;
      timeout <= 1'b0;
      asm_w <= '0;
      shreg <= '0;
      o_tx_data <= '0;
      o_tx_valid <= 1'b0;
      o_instruction_write_enable <= 1'b0;
      o_instruction_address <= '0;
      o_instruction_data <= '0;
      o_debug_mips_register_number <= '0;
      o_debug_address <= '0;
      o_halted <= 1'b0;
    end else begin
      o_instruction_write_enable <= 1'b0;
      case (state)
        IDLE: if (i_rx_valid) begin
          if (i_rx_data == 8'h4C) state <= LD_CNT;
          else if (i_rx_data == 8'h53 || i_rx_data == 8'h43) begin
            didx <= '0;
            bidx <= '0;
            run_cnt <= '0;
            timeout <= 1'b0;
            state <= o_halted ? DP_SEL : (i_rx_data == 8'h53) ? STEP : RUN;
          end
        end
        LD_CNT: if (i_rx_valid) begin
          wcnt <= i_rx_data;
          widx <= '0;
          bidx <= '0;
          o_halted <= (i_rx_data == 8'h00) ? 1'b0 : o_halted;
          o_tx_data <= (i_rx_data == 8'h00) ? 8'h4B : o_tx_data;
          o_tx_valid <= i_rx_data == 8'h00;
          state <= (i_rx_data == 8'h00) ? ACK : LD_BYTE;
        end
        LD_BYTE: if (i_rx_valid) begin
          asm_w <= {i_rx_data, asm_w[NB-9:8]};
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            o_instruction_data <= {i_rx_data, asm_w};
            o_instruction_address <= {{(NB-10){1'b0}}, widx, 2'b00};
            o_instruction_write_enable <= {1'b0, widx} < IMEM_LIM;
            state <= LD_WR;
          end
        end
        LD_WR: begin
          widx <= widx + 8'd1;
          o_halted <= (widx == wcnt - 8'd1) ? 1'b0 : o_halted;
          o_tx_data <= (widx == wcnt - 8'd1) ? 8'h4B : o_tx_data;
          o_tx_valid <= widx == wcnt - 8'd1;
          state <= (widx == wcnt - 8'd1) ? ACK : LD_BYTE;
        end
        ACK: if (accept) begin
          o_tx_valid <= 1'b0;
          o_tx_data <= '0;
          state <= IDLE;
        end
        STEP: state <= DP_SEL;
        RUN: begin
          o_halted <= o_halted | i_mips_wb_halt;
          timeout <= ~i_mips_wb_halt & (run_cnt == RUN_LAST);
          run_cnt <= run_cnt + 1'b1;
          state <= (i_mips_wb_halt || run_cnt == RUN_LAST) ? DP_SEL : RUN;
        end
        DP_SEL: begin
          o_debug_mips_register_number <= didx[4:0] - 5'd1;
          o_debug_address <= {{(NB-8){1'b0}}, didx - 6'd33, 2'b00};
          o_halted <= o_halted | ((didx == 6'd0) & i_mips_wb_halt);
          state <= DP_LATCH;
        end
        DP_LATCH: begin
          {shreg, o_tx_data} <= (didx == 6'd0) ? i_mips_pc : (didx <= 6'd32) ? i_mips_register_data : i_mips_data_memory;
          o_tx_valid <= 1'b1;
          state <= DP_SEND;
        end
        DP_SEND: if (accept) begin
          bidx <= bidx + 2'd1;
          {shreg, o_tx_data} <= {8'h00, shreg};
          if (bidx == 2'd3) begin
            o_tx_data <= timeout ? 8'hEE : 8'hA5;
            o_tx_valid <= didx == LAST;
            didx <= didx + 6'd1;
            state <= (didx == LAST) ? TRAILER : DP_SEL;
          end
        end
        TRAILER: if (accept) begin
          o_tx_valid <= 1'b0;
          o_tx_data <= '0;
          timeout <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
